// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: core writeback always wins, loader and debug share the rest round-robin.
// Optional starvation guard (core stall + protocol error flag) enabled by REGFILE_ARB_STARVE_GUARD_EN.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_we,
  input  logic [4:0]  core_a,
  input  logic [31:0] core_wd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_a,
  input  logic [31:0] ld_wd,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_a,
  input  logic [31:0] dbg_wd,
  output logic        core_stall,
  output logic        proto_err,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          rr;
  logic          sec_ok_c;
  logic          ld_xfer_c;
  logic          dbg_xfer_c;
  logic          sec_xfer_c;
  logic          win_c;
  logic [AW-1:0] win_a_c;
  logic [DW-1:0] win_wd_c;
  logic          commit_c;

  // Secondary grant: blocked by reset or a core write; contention resolved by rr.
  always_comb begin
    sec_ok_c  = !rst && !core_we;
    ld_ready  = sec_ok_c && ld_valid && (!dbg_valid || !rr);
    dbg_ready = sec_ok_c && dbg_valid && (!ld_valid || rr);
    ld_xfer_c  = ld_valid && ld_ready;
    dbg_xfer_c = dbg_valid && dbg_ready;
    sec_xfer_c = ld_xfer_c || dbg_xfer_c;
  end

  // Winning write selection.
  always_comb begin
    win_c    = 1'b0;
    win_a_c  = '0;
    win_wd_c = '0;
    if (core_we && !rst) begin
      win_c    = 1'b1;
      win_a_c  = core_a;
      win_wd_c = core_wd;
    end else if (ld_xfer_c) begin
      win_c    = 1'b1;
      win_a_c  = ld_a;
      win_wd_c = ld_wd;
    end else if (dbg_xfer_c) begin
      win_c    = 1'b1;
      win_a_c  = dbg_a;
      win_wd_c = dbg_wd;
    end
    // x0 is hardwired: handshake completes but nothing is written.
    commit_c = win_c && (win_a_c != AW'(0));
  end

  // Write port register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
      rr  <= 1'b0;
    end else begin
      we3 <= commit_c;
      if (commit_c) begin
        a3  <= win_a_c;
        wd3 <= win_wd_c;
      end
      if (ld_xfer_c) begin
        rr <= 1'b1;
      end else if (dbg_xfer_c) begin
        rr <= 1'b0;
      end
    end
  end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  // Waiting-cycle counter for pending secondary requests, saturating at LIMIT.
  always_comb begin
    cnt_nxt_c = cnt;
    if (sec_xfer_c || !(ld_valid || dbg_valid)) begin
      cnt_nxt_c = '0;
    end else if (cnt != LIMIT) begin
      cnt_nxt_c = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      core_stall <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      cnt <= cnt_nxt_c;
      if (sec_xfer_c) begin
        core_stall <= 1'b0;
      end else if (cnt_nxt_c == LIMIT) begin
        core_stall <= 1'b1;
      end
      if (core_stall && core_we) begin
        proto_err <= 1'b1;
      end
    end
  end
`else
  assign core_stall = 1'b0;
  assign proto_err  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios plus constrained-random traffic.
module tb_regfile_write_arbiter;

  localparam int unsigned LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_a;
  logic [31:0] core_wd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_a;
  logic [31:0] ld_wd;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_a;
  logic [31:0] dbg_wd;
  logic        core_stall;
  logic        proto_err;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_a(core_a), .core_wd(core_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_wd(ld_wd),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_a(dbg_a), .dbg_wd(dbg_wd),
    .core_stall(core_stall), .proto_err(proto_err),
    .we3(we3), .a3(a3), .wd3(wd3)
  );

  typedef struct {
    int          due;
    logic [4:0]  a;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  // Reference state: who is preferred next, how long secondaries have waited, stall/error flags.
  bit  m_prefer_dbg = 1'b0;
  int  m_wait       = 0;
  bit  m_stall      = 1'b0;
  bit  m_perr       = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] wd);
    wr_t w;
    if (a != 5'd0) begin
      w.due = cyc + 1;
      w.a   = a;
      w.wd  = wd;
      exp_q.push_back(w);
    end
  endtask

  task automatic clr();
    core_we = 1'b0; core_a = '0; core_wd = '0;
    ld_valid = 1'b0; ld_a = '0; ld_wd = '0;
    dbg_valid = 1'b0; dbg_a = '0; dbg_wd = '0;
  endtask

  // One clock cycle: check grants against the rules, advance the model, then check registered flags.
  task automatic step(output logic ldr, output logic dbr);
    bit lg, dg;
    #1;
    ldr = ld_ready;
    dbr = dbg_ready;
    lg  = 1'b0;
    dg  = 1'b0;
    chk("ready_onehot", 32'(ld_ready & dbg_ready), 32'd0);
    if (rst || core_we) begin
      chk("ready_blocked", 32'({ld_ready, dbg_ready}), 32'd0);
    end else begin
      if (ld_valid && dbg_valid) begin
        lg = !m_prefer_dbg;
        dg = m_prefer_dbg;
      end else begin
        lg = ld_valid;
        dg = dbg_valid;
      end
      if (ld_valid)  chk("ld_ready", 32'(ld_ready), 32'(lg));
      if (dbg_valid) chk("dbg_ready", 32'(dbg_ready), 32'(dg));
    end
    if (rst) begin
      m_prefer_dbg = 1'b0;
      m_wait       = 0;
      m_stall      = 1'b0;
      m_perr       = 1'b0;
    end else begin
      if (core_we) begin
        push_wr(core_a, core_wd);
`ifdef REGFILE_ARB_STARVE_GUARD_EN
        if (m_stall) m_perr = 1'b1;
`endif
      end else if (lg) begin
        push_wr(ld_a, ld_wd);
        m_prefer_dbg = 1'b1;
      end else if (dg) begin
        push_wr(dbg_a, dbg_wd);
        m_prefer_dbg = 1'b0;
      end
`ifdef REGFILE_ARB_STARVE_GUARD_EN
      if (lg || dg) begin
        m_wait  = 0;
        m_stall = 1'b0;
      end else if (!(ld_valid || dbg_valid)) begin
        m_wait = 0;
      end else begin
        if (m_wait < int'(LIM)) m_wait++;
        if (m_wait == int'(LIM)) m_stall = 1'b1;
      end
`endif
    end
    @(posedge clk);
    #2;
    chk("core_stall", 32'(core_stall), 32'(m_stall));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
  endtask

  // Write-port monitor: every presented write must match the oldest expected one, on time.
  always @(posedge clk) begin
    wr_t w;
    cyc++;
    #1;
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(we3), 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.due));
        chk("wr_a3", 32'(a3), 32'(w.a));
        chk("wr_wd3", wd3, w.wd);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      w = exp_q.pop_front();
      chk("missing_write_we3", 32'(we3), 32'd1);
    end
  end

  initial begin
    logic ldr, dbr;
    int   seen;

    clr();
    rst = 1'b1;
    step(ldr, dbr);
    step(ldr, dbr);
    rst = 1'b0;
    chk("reset_we3", 32'(we3), 32'd0);
    chk("reset_a3", 32'(a3), 32'd0);
    chk("reset_wd3", wd3, 32'd0);

    // Core-only write, then idle.
    core_we = 1'b1; core_a = 5'd5; core_wd = 32'h0000_00AA;
    step(ldr, dbr);
    clr();
    chk("core_we3", 32'(we3), 32'd1);
    chk("core_a3", 32'(a3), 32'd5);
    chk("core_wd3", wd3, 32'h0000_00AA);
    step(ldr, dbr);
    chk("core_idle_we3", 32'(we3), 32'd0);

    // Core collides with loader; loader goes next cycle.
    core_we = 1'b1; core_a = 5'd1; core_wd = 32'h0000_1234;
    ld_valid = 1'b1; ld_a = 5'd2; ld_wd = 32'hDEAD_BEEF;
    step(ldr, dbr);
    chk("collide_ld_ready", 32'(ldr), 32'd0);
    core_we = 1'b0;
    step(ldr, dbr);
    chk("after_ld_ready", 32'(ldr), 32'd1);
    clr();
    chk("ld_we3", 32'(we3), 32'd1);
    chk("ld_a3", 32'(a3), 32'd2);
    chk("ld_wd3", wd3, 32'hDEAD_BEEF);
    step(ldr, dbr);

    // Round-robin from reset with both secondaries held.
    rst = 1'b1;
    step(ldr, dbr);
    rst = 1'b0;
    ld_valid = 1'b1; ld_a = 5'd3; ld_wd = 32'h3333_0000;
    dbg_valid = 1'b1; dbg_a = 5'd4; dbg_wd = 32'h4444_0000;
    for (int i = 0; i < 4; i++) begin
      step(ldr, dbr);
      chk("rr_ld_grant", 32'(ldr), 32'(i % 2 == 0));
      chk("rr_dbg_grant", 32'(dbr), 32'(i % 2 == 1));
    end
    clr();
    step(ldr, dbr);

    // Debug write to x0: handshake only.
    dbg_valid = 1'b1; dbg_a = 5'd0; dbg_wd = 32'h1111_1111;
    step(ldr, dbr);
    chk("x0_dbg_ready", 32'(dbr), 32'd1);
    clr();
    chk("x0_we3", 32'(we3), 32'd0);
    step(ldr, dbr);

    // Reset right after a loader transfer.
    ld_valid = 1'b1; ld_a = 5'd7; ld_wd = 32'h7777_7777;
    step(ldr, dbr);
    ld_a = 5'd8; ld_wd = 32'h8888_8888;
    rst = 1'b1;
    step(ldr, dbr);
    rst = 1'b0;
    chk("rst_mid_we3", 32'(we3), 32'd0);
    chk("rst_mid_stall", 32'(core_stall), 32'd0);
    dbg_valid = 1'b1; dbg_a = 5'd9; dbg_wd = 32'h9999_9999;
    step(ldr, dbr);
    chk("rst_mid_rr_ld", 32'(ldr), 32'd1);
    clr();
    step(ldr, dbr);

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    // Starvation: stall after LIM waiting cycles, clear on transfer, then a protocol violation.
    rst = 1'b1;
    step(ldr, dbr);
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      core_we = 1'b1; core_a = 5'd12; core_wd = 32'hC0DE_0000 + 32'(pass);
      ld_valid = 1'b1; ld_a = 5'(10 + pass); ld_wd = 32'h1D00_0000 + 32'(pass);
      seen = 0;
      for (int i = 1; i <= 20 && seen == 0; i++) begin
        step(ldr, dbr);
        if (core_stall) seen = i;
      end
      chk("stall_latency", 32'(seen), 32'(LIM));
      if (pass == 1) begin
        step(ldr, dbr);
        chk("proto_err_set", 32'(proto_err), 32'd1);
      end
      core_we = 1'b0;
      step(ldr, dbr);
      chk("stall_ld_ready", 32'(ldr), 32'd1);
      chk("stall_cleared", 32'(core_stall), 32'd0);
    end
    clr();
    step(ldr, dbr);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    step(ldr, dbr);
    rst = 1'b0;
    chk("proto_err_reset", 32'(proto_err), 32'd0);
`endif

    // Random traffic; requesters hold each request until it is transferred.
    clr();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      core_we = !m_stall && ($urandom_range(0, 99) < 55);
      core_a  = 5'($urandom);
      core_wd = $urandom;
      if (!ld_valid && $urandom_range(0, 99) < 50) begin
        ld_valid = 1'b1; ld_a = 5'($urandom); ld_wd = $urandom;
      end
      if (!dbg_valid && $urandom_range(0, 99) < 50) begin
        dbg_valid = 1'b1; dbg_a = 5'($urandom); dbg_wd = $urandom;
      end
      step(ldr, dbr);
      if (ld_valid && ldr) ld_valid = 1'b0;
      if (dbg_valid && dbr) dbg_valid = 1'b0;
    end
    rst = 1'b0;
    clr();
    for (int i = 0; i < 3; i++) step(ldr, dbr);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, cycles a secondary request may wait before the core is stalled (range 2..15).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 core_we  input  1  core writeback request, single-cycle, no backpressure.
REQ-005 core_a  input  5  core destination register.
REQ-006 core_wd  input  32  core write data.
REQ-007 ld_valid  input  1  loader write request.
REQ-008 ld_ready  output  1  loader request accepted this cycle when high with ld_valid.
REQ-009 ld_a  input  5  loader destination register.
REQ-010 ld_wd  input  32  loader write data.
REQ-011 dbg_valid  input  1  debug write request.
REQ-012 dbg_ready  output  1  debug request accepted this cycle when high with dbg_valid.
REQ-013 dbg_a  input  5  debug destination register.
REQ-014 dbg_wd  input  32  debug write data.
REQ-015 core_stall  output  1  registered; core shall not assert core_we while high.
REQ-016 proto_err  output  1  sticky; core wrote while stalled.
REQ-017 we3  output  1  registered register-file write enable.
REQ-018 a3  output  5  registered register-file write address.
REQ-019 wd3  output  32  registered register-file write data.

Function
REQ-020 Priority: core_we=1 always wins; ld_ready=dbg_ready=0 in that cycle.
REQ-021 With core_we=0, loader and debug arbitrate round-robin via 1-bit pointer rr: rr=0 prefers loader, rr=1 prefers debug; a lone valid requester wins regardless of rr.
REQ-022 ld_ready/dbg_ready combinational from core_we, ld_valid, dbg_valid, rr; at most one high per cycle; ready may be high with valid low (no transfer).
REQ-023 Transfer = valid && ready; after a loader transfer rr<=1, after a debug transfer rr<=0, otherwise rr holds.
REQ-024 Requesters shall hold valid, address and data stable until transfer; arbiter does not check this.
REQ-025 Latency: the winning write (core or transfer) appears on we3/a3/wd3 exactly one cycle later, for exactly one cycle.
REQ-026 No winner in a cycle: we3<=0 next cycle; a3/wd3 hold previous values.
REQ-027 Winner with address 0: handshake completes (ready high), rr updates, but we3<=0 next cycle.
REQ-028 Starvation counter (4 bits): increments while (ld_valid||dbg_valid) and no secondary transfer, saturating at STARVE_LIMIT; clears on any secondary transfer or when both valids low.
REQ-029 core_stall<=1 on the edge where counter equals STARVE_LIMIT; core_stall<=0 on the edge following the next secondary transfer.
REQ-030 While core_stall=1 and core_we=0, a secondary requester is granted the same cycle per REQ-021.
REQ-031 If core_stall=1 and core_we=1: core still wins (REQ-020); proto_err<=1 and remains 1 until reset.

Reset
REQ-032 rst=1 at a rising edge: we3=0, a3=0, wd3=0, rr=0, counter=0, core_stall=0, proto_err=0.
REQ-033 While rst=1, ld_ready=dbg_ready=0; a request pending at reset is not transferred and must be re-presented (it remains presented if valid is held).
REQ-034 A write registered in the cycle reset asserts is discarded (we3=0 after the reset edge).

Configuration
REQ-035 Macro REGFILE_ARB_STARVE_GUARD_EN: defined -> counter, core_stall, proto_err behave per REQ-028..031.
REQ-036 Macro undefined -> no counter; core_stall and proto_err tied 0; secondary requesters may starve indefinitely under continuous core_we.

Verification
REQ-037 Core only: core_we=1, core_a=5, core_wd=0x000000AA -> next cycle we3=1, a3=5, wd3=0xAA; following idle cycle we3=0.
REQ-038 Simultaneous: core_we=1 (a=1) with ld_valid=1 (a=2, 0xDEADBEEF) -> ld_ready=0; next cycle core_we=0 -> ld_ready=1, one cycle later we3=1, a3=2, wd3=0xDEADBEEF.
REQ-039 Round-robin: ld_valid and dbg_valid held high, core idle, after reset -> grants loader, debug, loader, debug on consecutive cycles.
REQ-040 x0: dbg_valid=1, dbg_a=0, wd=0x11111111 -> dbg_ready=1, next cycle we3=0.
REQ-041 Starvation (macro defined, STARVE_LIMIT=8): core_we held 1, ld_valid=1 -> core_stall=1 after 8 cycles; core drops core_we -> loader transferred, core_stall=0 next edge; repeat with core_we held -> proto_err=1 sticky.
REQ-042 Reset mid-operation: rst=1 the cycle after a loader transfer -> we3=0, rr=0, core_stall=0 after the reset edge.
